// File: rtl/output_packer_if.sv
// Packer-side bundle: FIFO read port, packed-word stream and frame control/status.
// master is the packer, slave is the surrounding FIFO/consumer/controller.
interface output_packer_if #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 20
);
    logic                 fifo_valid;
    logic                 fifo_rd_en;
    logic [W-1:0]         fifo_rd_data;
    logic                 start;
    logic [CNT_W-1:0]     expected_count;
    logic [W*LANES-1:0]   word_data;
    logic                 word_valid;
    logic                 word_ack;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     pixel_count;

    modport master (
        input  fifo_valid, fifo_rd_data, start, expected_count, word_ack,
        output fifo_rd_en, word_data, word_valid, busy, done, pixel_count
    );

    modport slave (
        output fifo_valid, fifo_rd_data, start, expected_count, word_ack,
        input  fifo_rd_en, word_data, word_valid, busy, done, pixel_count
    );
endinterface

// File: rtl/output_packer.sv
// Pops pixels one at a time from a registered-output FIFO and packs LANES of them
// into a word, holding each word until the consumer acknowledges it.
module output_packer #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 20
) (
    input  logic              clk,
    input  logic              rstn,
    output_packer_if.master   bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         pix_q, pix_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [LANES-1:0][W-1:0]  buf_q, buf_d;
    logic                     done_q, done_d;

    logic [CNT_W-1:0]         pix_inc;
    logic                     word_full;

    assign pix_inc   = pix_q + CNT_W'(1);
    // CAPTURE closes the word on the last lane or the last pixel of the frame
    assign word_full = (lane_q == LW'(LANES-1)) || (pix_inc == cnt_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && bus.expected_count != '0) state_d = FETCH;
            FETCH:   if (bus.fifo_valid) state_d = CAPTURE;
            CAPTURE: state_d = word_full ? HOLD : FETCH;
            HOLD:    if (bus.word_ack) state_d = (pix_q == cnt_q) ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = (state_q == FETCH) && bus.fifo_valid;
        bus.word_valid = (state_q == HOLD);
        bus.busy       = (state_q != IDLE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        pix_d  = pix_q;
        lane_d = lane_q;
        buf_d  = buf_q;
        done_d = done_q;
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.expected_count != '0) begin
                    cnt_d  = bus.expected_count;
                    pix_d  = '0;
                    lane_d = '0;
                    buf_d  = '0;
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            CAPTURE: begin
                // fifo_rd_data is the pixel popped on the preceding FETCH cycle
                buf_d[lane_q] = bus.fifo_rd_data;
                pix_d         = pix_inc;
                if (!word_full) lane_d = lane_q + LW'(1);
            end
            HOLD: if (bus.word_ack) begin
                buf_d  = '0;
                lane_d = '0;
                if (pix_q == cnt_q) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            pix_q  <= '0;
            lane_q <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pix_q  <= pix_d;
            lane_q <= lane_d;
            buf_q  <= buf_d;
            done_q <= done_d;
        end
    end

    assign bus.word_data   = buf_q;
    assign bus.done        = done_q;
    assign bus.pixel_count = pix_q;
endmodule

// File: doc/output_packer.md
OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 Parameter: W, 8, pixel width in bits.
REQ-002 Parameter: LANES, 4, pixels packed per output word.
REQ-003 Parameter: CNT_W, 20, width of the pixel counters.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rstn  input  1  asynchronous active-low reset; no other reset input.
REQ-006 Port: fifo_valid  input  1  upstream FIFO non-empty.
REQ-007 Port: fifo_rd_en  output  1  pop request to upstream FIFO; the popped data is registered by the FIFO and appears on fifo_rd_data one cycle later.
REQ-008 Port: fifo_rd_data  input  W  popped pixel.
REQ-009 Port: start  input  1  single-cycle frame start pulse.
REQ-010 Port: expected_count  input  CNT_W  pixels in frame, sampled on accepted start.
REQ-011 Port: word_data  output  W*LANES  packed word; lane 0 in bits [W-1:0].
REQ-012 Port: word_valid  output  1  word_data holds an unconsumed word.
REQ-013 Port: word_ack  input  1  consumer took word_data.
REQ-014 Port: busy  output  1  frame in progress.
REQ-015 Port: done  output  1  sticky frame-complete flag.
REQ-016 Port: pixel_count  output  CNT_W  pixels captured this frame.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, CAPTURE and HOLD; busy SHALL be 1 in every state except IDLE.
REQ-018 IDLE: start with expected_count != 0 SHALL latch expected_count, clear pixel_count, lane index, word buffer and done, and enter FETCH.
REQ-019 IDLE: start with expected_count == 0 SHALL set done the next cycle and remain in IDLE.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 fifo_rd_en SHALL be combinational: 1 exactly when the state is FETCH and fifo_valid is 1; FETCH SHALL go to CAPTURE on that cycle and stay in FETCH otherwise.
REQ-022 CAPTURE SHALL write fifo_rd_data into the current lane of the word buffer and increment pixel_count.
REQ-023 CAPTURE SHALL enter HOLD if the lane index equals LANES-1 or the incremented pixel_count equals the latched count; otherwise it SHALL increment the lane index and return to FETCH.
REQ-024 Each pixel SHALL therefore take 2 cycles minimum, with no FIFO read issued from CAPTURE or HOLD.
REQ-025 word_valid SHALL be 1 only in HOLD; word_data SHALL be stable throughout HOLD.
REQ-026 Unfilled lanes of a final partial word SHALL read 0.
REQ-027 HOLD with word_ack SHALL clear the word buffer and lane index.
REQ-028 HOLD with word_ack SHALL then enter IDLE and set done if pixel_count equals the latched count; otherwise it SHALL enter FETCH.
REQ-029 word_ack outside HOLD SHALL be ignored.
REQ-030 done SHALL remain 1 until the next accepted start.
REQ-031 pixel_count SHALL hold its final value in IDLE.
REQ-032 The block SHALL never pop more pixels than the latched count, so excess FIFO data is left in the FIFO.

Reset
REQ-033 rstn low SHALL immediately force IDLE with fifo_rd_en=0, word_valid=0, word_data=0, busy=0, done=0 and pixel_count=0, including when asserted mid-frame.
REQ-034 After rstn deasserts, the block SHALL wait for a new start; a word in progress is discarded.

Verification
REQ-035 start with count=8, FIFO preloaded 0x01..0x08, ack each word the cycle it appears -> words 0x04030201 then 0x08070605; done=1; pixel_count=8; exactly 8 pops.
REQ-036 Count=6 with pixels 0xA0..0xA5 -> 0xA3A2A1A0 then 0x0000A5A4; done=1.
REQ-037 Count=4 with FIFO empty 10 cycles before data arrives -> fifo_rd_en stays 0 while empty; the word completes afterwards unchanged.
REQ-038 Count=4 with word_ack withheld 20 cycles -> word_valid and word_data stable, no pops during HOLD; 4 pops total.
REQ-039 Count=0 start -> done=1 next cycle, busy=0, no pops; a start while busy is ignored, leaving the latched count unchanged.
REQ-040 rstn pulsed low after 3 pixels of a count=8 frame -> all outputs 0 asynchronously; a new start with count=4 runs normally from lane 0.
